// File: rtl/root_host_bridge_pkg.sv
// Shared definitions for the root host bridge: command encodings, the packed
// command word stored in the FIFO, and the bridge FSM state type.
package root_host_bridge_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'd0,
    CMD_READ  = 2'd1,
    CMD_START = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_op_e;

  localparam logic [15:0] START_ADDR = 16'hFFFF;
  localparam int          CMD_WIDTH  = 34;

  typedef struct packed {
    cmd_op_e     op;
    logic [15:0] addr;
    logic [15:0] data;
  } cmd_word_t;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // A write to the start address launches a run exactly like an explicit START.
  function automatic logic is_start_cmd(input cmd_word_t c);
    return (c.op == CMD_START) || ((c.op == CMD_WRITE) && (c.addr == START_ADDR));
  endfunction

endpackage

// File: rtl/root_host_bridge_if.sv
// Host command and controller handshake bundle for the root host bridge.
// master = bridge side, slave = host/controller side.
interface root_host_bridge_if #(
  parameter int CYC_CNT_WIDTH = 32
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [15:0]              cmd_addr;
  logic [15:0]              cmd_data;
  logic                     busy;
  logic                     run_done;
  logic [CYC_CNT_WIDTH-1:0] run_cycles;
  logic                     cmd_err;
  logic                     write_en;
  logic [15:0]              write_addr;
  logic [15:0]              write_data;
  logic                     write_rdy;
  logic                     read_en;
  logic [15:0]              read_addr;
  logic                     read_rdy;
  logic                     interrupt;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, write_rdy, read_rdy, interrupt,
    output cmd_ready, busy, run_done, run_cycles, cmd_err,
           write_en, write_addr, write_data, read_en, read_addr
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, write_rdy, read_rdy, interrupt,
    input  cmd_ready, busy, run_done, run_cycles, cmd_err,
           write_en, write_addr, write_data, read_en, read_addr
  );
endinterface

// File: rtl/root_host_bridge_cmd_fifo.sv
// Synchronous command FIFO with async reset; head entry visible on pop_data.
// A push is refused whenever the FIFO is full, even if a pop happens that cycle.
module root_cmd_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/root_host_bridge.sv
// Root host bridge: queues host commands and replays them on the controller
// write/read handshakes, holding issue off while a computation run is active.
module root_host_bridge #(
  parameter int FIFO_DEPTH    = 8,
  parameter int CYC_CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  root_host_bridge_if.master   bus
);
  import root_host_bridge_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                   state_r;
  state_e                   state_nx_s;
  cmd_word_t                head_s;
  logic [CMD_WIDTH-1:0]     fifo_rdata_s;
  logic [CW-1:0]            count_s;
  logic                     full_s;
  logic                     empty_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     start_hs_s;
  logic                     rsvd_s;
  logic                     wen_s;
  logic                     ren_s;
  logic [15:0]              waddr_s;
  logic [15:0]              wdata_s;
  logic [15:0]              raddr_s;
  logic [CYC_CNT_WIDTH-1:0] run_cnt_r;
  logic [CYC_CNT_WIDTH-1:0] cnt_inc_s;
  logic [CYC_CNT_WIDTH-1:0] run_cycles_r;
  logic                     run_done_r;
  logic                     cmd_err_r;

  assign push_s = bus.cmd_valid && !full_s;
  assign head_s = cmd_word_t'(fifo_rdata_s);

  root_cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data ({bus.cmd_op, bus.cmd_addr, bus.cmd_data}),
    .pop       (pop_s),
    .pop_data  (fifo_rdata_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Saturating increment of the run counter.
  always_comb begin
    if (&run_cnt_r) begin
      cnt_inc_s = run_cnt_r;
    end else begin
      cnt_inc_s = run_cnt_r + {{(CYC_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Issue mux and next-state logic; idle address/data lines are held at zero.
  always_comb begin
    state_nx_s = state_r;
    wen_s      = 1'b0;
    ren_s      = 1'b0;
    waddr_s    = 16'h0000;
    wdata_s    = 16'h0000;
    raddr_s    = 16'h0000;
    rsvd_s     = 1'b0;
    pop_s      = 1'b0;
    start_hs_s = 1'b0;
    case (state_r)
      ST_ISSUE: begin
        if (!empty_s) begin
          if (is_start_cmd(head_s)) begin
            wen_s   = 1'b1;
            waddr_s = START_ADDR;
            wdata_s = 16'h0000;
          end else begin
            case (head_s.op)
              CMD_WRITE: begin
                wen_s   = 1'b1;
                waddr_s = head_s.addr;
                wdata_s = head_s.data;
              end
              CMD_READ: begin
                ren_s   = 1'b1;
                raddr_s = head_s.addr;
              end
              CMD_RSVD: rsvd_s = 1'b1;
              default:  rsvd_s = 1'b0;
            endcase
          end
        end else begin
          rsvd_s = 1'b0;
        end
        pop_s      = (wen_s && bus.write_rdy) || (ren_s && bus.read_rdy) || rsvd_s;
        start_hs_s = wen_s && bus.write_rdy && is_start_cmd(head_s);
        if (start_hs_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      ST_RUN: begin
        if (bus.interrupt) begin
          state_nx_s = ST_ISSUE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: state_nx_s = ST_ISSUE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_ISSUE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Run counter, completion report and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt_r    <= {CYC_CNT_WIDTH{1'b0}};
      run_cycles_r <= {CYC_CNT_WIDTH{1'b0}};
      run_done_r   <= 1'b0;
      cmd_err_r    <= 1'b0;
    end else begin
      cmd_err_r  <= rsvd_s;
      run_done_r <= 1'b0;
      if (start_hs_s) begin
        run_cnt_r <= {CYC_CNT_WIDTH{1'b0}};
      end else if (state_r == ST_RUN) begin
        run_cnt_r <= cnt_inc_s;
      end
      // Interrupt on this edge counts the current cycle, hence counter + 1.
      if ((state_r == ST_RUN) && bus.interrupt) begin
        run_cycles_r <= cnt_inc_s;
        run_done_r   <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready  = !full_s;
  assign bus.busy       = (count_s != {CW{1'b0}}) || (state_r == ST_RUN);
  assign bus.run_done   = run_done_r;
  assign bus.run_cycles = run_cycles_r;
  assign bus.cmd_err    = cmd_err_r;
  assign bus.write_en   = wen_s;
  assign bus.write_addr = waddr_s;
  assign bus.write_data = wdata_s;
  assign bus.read_en    = ren_s;
  assign bus.read_addr  = raddr_s;

endmodule
